syn_mem_dp: RTL

- Parametrised simple-dual-port synchronous memory: one write port, one read port, same clock.
- Generalises the single-port syn_mem with:
  - separate read and write addresses
  - byte-lane write enables
  - selectable read latency with a valid strobe
  - defined read-during-write behaviour
- Used as the storage primitive for PUF response buffers and challenge tables.

---
 rtl/syn_mem_dp.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/syn_mem_dp.sv
// Simple-dual-port synchronous RAM with byte-lane writes, write-first read bypass and a 1- or 2-cycle read pipeline.
// Define SYN_MEM_CLEAR_EN to zero the whole array after every reset (port is not ready during the sweep).
module syn_mem_dp #(
    parameter int ADDR_SIZE  = 4,
    parameter int WORD_SIZE  = 8,
    parameter int BYTE_SIZE  = 8,
    parameter int RD_LATENCY = 1,
    localparam int NBE       = WORD_SIZE / BYTE_SIZE
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_wen,
    input  logic [NBE-1:0]       I_wbe,
    input  logic [ADDR_SIZE-1:0] I_waddr,
    input  logic [WORD_SIZE-1:0] I_wdata,
    input  logic                 I_ren,
    input  logic [ADDR_SIZE-1:0] I_raddr,
    output logic [WORD_SIZE-1:0] O_rdata,
    output logic                 O_rvalid,
    output logic                 O_ready
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("syn_mem_dp: RD_LATENCY must be 1 or 2");
        end
        if ((WORD_SIZE % BYTE_SIZE) != 0) begin : g_bad_lanes
            $error("syn_mem_dp: WORD_SIZE must be a multiple of BYTE_SIZE");
        end
    endgenerate

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic                 ready;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 clr_wr;
    logic [ADDR_SIZE-1:0] clr_addr;

`ifdef SYN_MEM_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0] state;

    // Sweep one address per clock; leave CLEAR right after the last address is written.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) begin
                state <= ST_IDLE;
            end
        end
    end

    assign ready  = (state == ST_IDLE);
    assign clr_wr = (state == ST_CLEAR) && !I_rst;
`else
    assign ready    = 1'b1;
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
`endif

    // Reset dominates: nothing presented on a reset edge is accepted.
    assign wr_acc  = I_wen && ready && !I_rst;
    assign rd_acc  = I_ren && ready && !I_rst;
    assign O_ready = ready;

    logic [NBE-1:0]       port_lanes;
    logic [ADDR_SIZE-1:0] port_addr;
    logic [WORD_SIZE-1:0] port_data;

    always_comb begin
        port_lanes = '0;
        port_addr  = I_waddr;
        port_data  = I_wdata;
        if (clr_wr) begin
            port_lanes = '1;
            port_addr  = clr_addr;
            port_data  = '0;
        end else if (wr_acc) begin
            port_lanes = I_wbe;
        end
    end

    always_ff @(posedge I_clk) begin
        for (int k = 0; k < NBE; k++) begin
            if (port_lanes[k]) begin
                mem[port_addr][k*BYTE_SIZE +: BYTE_SIZE] <= port_data[k*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    // Write-first bypass: a same-address write on the read edge shows its enabled lanes.
    logic [WORD_SIZE-1:0] rd_word;

    always_comb begin
        rd_word = mem[I_raddr];
        if (wr_acc && (I_waddr == I_raddr)) begin
            for (int k = 0; k < NBE; k++) begin
                if (I_wbe[k]) begin
                    rd_word[k*BYTE_SIZE +: BYTE_SIZE] = I_wdata[k*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    logic [WORD_SIZE-1:0] rdata_q;
    logic                 rvalid_q;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                 s1_valid;
            logic [WORD_SIZE-1:0] s1_data;

            always_ff @(posedge I_clk) begin
                if (I_rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    s1_valid <= rd_acc;
                    if (rd_acc) begin
                        s1_data <= rd_word;
                    end
                    rvalid_q <= s1_valid;
                    if (s1_valid) begin
                        rdata_q <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge I_clk) begin
                if (I_rst) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= rd_word;
                    end
                end
            end
        end
    endgenerate

    assign O_rdata  = rdata_q;
    assign O_rvalid = rvalid_q;

endmodule
